// File: rtl/deint_pkg.sv
// Shared definitions for the block deinterleaver (and the future interleaver):
// default matrix geometry, reader state encoding and the row-major address helper.
package deint_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 8;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  function automatic int unsigned deint_addr(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/deint_bank_ram.sv
// One bank of deinterleaver storage: one write port, one read port with a
// registered read that holds its value whenever no read is issued.
module deint_bank_ram #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem_q [DEPTH];
  logic rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read register doubles as the block's bit_out register, so it resets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 1'b0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/block_deinterleaver.sv
// Serial ping-pong block deinterleaver: row-major write, column-major read.
// Define BLK_DEINT_FRAME_MARK_EN to add frame_start_out marking element (0,0).
module block_deinterleaver
  import deint_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic valid_in,
  output logic in_ready,
  output logic bit_out,
  output logic valid_out,
  output logic overflow
`ifdef BLK_DEINT_FRAME_MARK_EN
  ,
  output logic frame_start_out
`endif
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic          wb_q, rb_q, sel_q;
  logic [RW-1:0] wr_q, rr_q;
  logic [CW-1:0] wc_q, rc_q;
  logic [1:0]    bank_full_q;
  rd_state_t     state_q;
  logic          valid_q, overflow_q;
  logic [1:0]    rdata;
  logic          accept, wr_last, rd_fire, rd_last;
  logic [AW-1:0] waddr_d, raddr_d;
`ifdef BLK_DEINT_FRAME_MARK_EN
  logic          frame_q;
`endif

  assign in_ready = !bank_full_q[wb_q];
  assign accept   = valid_in && in_ready;
  assign wr_last  = accept && (wr_q == ROW_LAST) && (wc_q == COL_LAST);
  assign rd_fire  = (state_q == RD_READ);
  assign rd_last  = rd_fire && (rr_q == ROW_LAST) && (rc_q == COL_LAST);
  assign waddr_d  = AW'(deint_addr(32'(wr_q), 32'(wc_q), COLS));
  assign raddr_d  = AW'(deint_addr(32'(rr_q), 32'(rc_q), COLS));

  // Writer: row-major fill of bank wb; hands the bank over on the N-th bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= 1'b0;
      wr_q <= '0;
      wc_q <= '0;
    end else if (accept) begin
      if (wc_q == COL_LAST) begin
        wc_q <= '0;
        if (wr_q == ROW_LAST) begin
          wr_q <= '0;
          wb_q <= ~wb_q;
        end else begin
          wr_q <= wr_q + 1'b1;
        end
      end else begin
        wc_q <= wc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (valid_in && !in_ready) begin
      overflow_q <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      // Writer sets and reader clears always target different banks.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bank_full_q[gi] <= 1'b0;
        end else if (wr_last && (wb_q == 1'(gi))) begin
          bank_full_q[gi] <= 1'b1;
        end else if (rd_last && (rb_q == 1'(gi))) begin
          bank_full_q[gi] <= 1'b0;
        end
      end

      deint_bank_ram #(.DEPTH(N)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept && (wb_q == 1'(gi))),
        .waddr_i (waddr_d),
        .wdata_i (bit_in),
        .re_i    (rd_fire && (rb_q == 1'(gi))),
        .raddr_i (raddr_d),
        .rdata_o (rdata[gi])
      );
    end
  endgenerate

  // Reader: column-major drain of bank rb; chains straight into the other
  // bank when it is already full so back-to-back blocks have no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RD_IDLE;
      rb_q    <= 1'b0;
      rr_q    <= '0;
      rc_q    <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
`ifdef BLK_DEINT_FRAME_MARK_EN
      frame_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        RD_IDLE: begin
          valid_q <= 1'b0;
          rr_q    <= '0;
          rc_q    <= '0;
`ifdef BLK_DEINT_FRAME_MARK_EN
          frame_q <= 1'b0;
`endif
          if (bank_full_q[rb_q]) begin
            state_q <= RD_READ;
          end
        end
        RD_READ: begin
          valid_q <= 1'b1;
          sel_q   <= rb_q;
`ifdef BLK_DEINT_FRAME_MARK_EN
          frame_q <= (rr_q == '0) && (rc_q == '0);
`endif
          if (rr_q == ROW_LAST) begin
            rr_q <= '0;
            if (rc_q == COL_LAST) begin
              rc_q <= '0;
              rb_q <= ~rb_q;
              if (!bank_full_q[~rb_q]) begin
                state_q <= RD_IDLE;
              end
            end else begin
              rc_q <= rc_q + 1'b1;
            end
          end else begin
            rr_q <= rr_q + 1'b1;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign bit_out   = rdata[sel_q];
  assign valid_out = valid_q;
  assign overflow  = overflow_q;
`ifdef BLK_DEINT_FRAME_MARK_EN
  assign frame_start_out = frame_q;
`endif

endmodule

// File: tb/tb_block_deinterleaver.sv
// Self-checking bench for block_deinterleaver (ROWS=4, COLS=8): vector table,
// randomized streaming against a permutation model, overflow and reset cases.
module tb_block_deinterleaver;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic valid_in = 1'b0;
  logic in_ready, bit_out, valid_out, overflow;
`ifdef BLK_DEINT_FRAME_MARK_EN
  logic frame_start_out;
`endif

  block_deinterleaver #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .bit_out   (bit_out),
    .valid_out (valid_out),
    .overflow  (overflow)
`ifdef BLK_DEINT_FRAME_MARK_EN
    ,
    .frame_start_out (frame_start_out)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: input element (r,c) lands at output beat c*ROWS+r.
  function automatic logic [N-1:0] permute(input logic [N-1:0] din);
    logic [N-1:0] o;
    o = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        o[c*ROWS + r] = din[r*COLS + c];
    return o;
  endfunction

  function automatic logic frame_ok(input int beat);
`ifdef BLK_DEINT_FRAME_MARK_EN
    return frame_start_out === (beat == 0);
`else
    return (beat >= 0);
`endif
  endfunction

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] dout;
  } vec_t;

  vec_t vecs [6];

  task automatic apply_block(input logic [N-1:0] din, input logic [N-1:0] exp, input string tag);
    int lat, gaps, ferr;
    logic [N-1:0] got;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bit_in   = din[i];
      valid_in = 1'b1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    bit_in   = 1'b0;
    lat = 1;
    while (!valid_out && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_int({tag, "_latency"}, lat, 3);
    got = '0; gaps = 0; ferr = 0;
    for (int j = 0; j < N; j++) begin
      if (!valid_out) gaps++;
      if (!frame_ok(j)) ferr++;
      got[j] = bit_out;
      @(negedge clk);
    end
    check_word({tag, "_data"}, got, exp);
    check_int({tag, "_gaps"}, gaps, 0);
    check_int({tag, "_frame"}, ferr, 0);
    check_bit({tag, "_valid_end"}, valid_out, 1'b0);
    check_bit({tag, "_hold"}, bit_out, exp[N-1]);
  endtask

  bit exp_q [$];

  task automatic stream(input int nblk, input int vprob, input string tag);
    int beats, cyc, gaps, ferr, oob;
    beats = 0; cyc = 0; gaps = 0; ferr = 0; oob = 0;
    fork
      begin : driver
        for (int b = 0; b < nblk; b++) begin
          logic [N-1:0] din;
          logic [N-1:0] pd;
          int i, guard;
          din = {$urandom, $urandom};
          i = 0; guard = 0;
          while (i < N && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (in_ready && ($urandom_range(99) < vprob)) begin
              valid_in = 1'b1;
              bit_in   = din[i];
              i++;
            end else begin
              valid_in = 1'b0;
            end
          end
          pd = permute(din);
          for (int k = 0; k < N; k++) exp_q.push_back(pd[k]);
        end
        @(negedge clk);
        valid_in = 1'b0;
      end
      begin : monitor
        while (beats < nblk * N && cyc < 8000) begin
          @(negedge clk);
          cyc++;
          if (valid_out) begin
            if (exp_q.size() == 0) begin
              oob++;
            end else begin
              check_bit($sformatf("%s_beat%0d", tag, beats), bit_out, exp_q.pop_front());
            end
            if (!frame_ok(beats % N)) ferr++;
            beats++;
          end else if (beats % N != 0) begin
            gaps++;
          end
        end
      end
    join
    check_int({tag, "_beats"}, beats, nblk * N);
    check_int({tag, "_unexpected"}, oob, 0);
    check_int({tag, "_gaps"}, gaps, 0);
    check_int({tag, "_frame"}, ferr, 0);
    check_bit({tag, "_overflow"}, overflow, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    check_int({tag, "_no_output"}, seen, 0);
  endtask

  initial begin
    vecs[0] = '{din: 32'h0000_0002, dout: 32'h0000_0010};   // impulse at (0,1)
    vecs[1] = '{din: 32'h8000_0200, dout: 32'h8000_0020};   // (1,1) and (3,7)
    vecs[2] = '{din: 32'h0000_0100, dout: 32'h0000_0002};   // (1,0)
    vecs[3] = '{din: 32'h0000_0080, dout: 32'h1000_0000};   // (0,7)
    vecs[4] = '{din: 32'hFFFF_FFFF, dout: 32'hFFFF_FFFF};
    vecs[5] = '{din: 32'h0000_0000, dout: 32'h0000_0000};

    // Reset held with valid_in toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_in = i[0];
      bit_in   = 1'b1;
      check_bit("rst_valid_out", valid_out, 1'b0);
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_overflow", overflow, 1'b0);
      check_bit("rst_bit_out", bit_out, 1'b0);
    end
    valid_in = 1'b0;
    bit_in   = 1'b0;
    rst      = 1'b0;
    idle_quiet("post_reset", 40);

    for (int v = 0; v < 6; v++)
      apply_block(vecs[v].din, vecs[v].dout, $sformatf("vec%0d", v));

    stream(4, 100, "stream_full");
    stream(3, 60, "stream_rand");

    // Continuous valid_in across three blocks: both banks are full when the
    // first bit of block 3 arrives, so that bit is refused.
    pulse_reset();
    for (int j = 0; j < 66; j++) begin
      @(negedge clk);
      check_bit($sformatf("ovf_ready%0d", j), in_ready, (j == 64) ? 1'b0 : 1'b1);
      check_bit($sformatf("ovf_flag%0d", j), overflow, (j >= 65) ? 1'b1 : 1'b0);
      valid_in = 1'b1;
      bit_in   = 1'($urandom);
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (80) @(negedge clk);
    check_bit("ovf_sticky", overflow, 1'b1);
    pulse_reset();
    @(negedge clk);
    check_bit("ovf_cleared", overflow, 1'b0);
    check_bit("ovf_ready_after_rst", in_ready, 1'b1);

    // Partial block of 13 bits discarded by reset.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      bit_in   = 1'b1;
    end
    pulse_reset();
    idle_quiet("midrst", 40);
    apply_block(vecs[1].din, vecs[1].dout, "midrst_block");
    apply_block(vecs[0].din, vecs[0].dout, "midrst_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
